// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encodings and default word limit
package imem_loader_pkg;
   typedef enum logic [2:0] {
      LD_IDLE = 3'd0,
      LD_LEN  = 3'd1,
      LD_LOAD = 3'd2,
      LD_CSUM = 3'd3,
      LD_DONE = 3'd4,
      LD_ERR  = 3'd5
   } ld_state_e;
   localparam int LD_MAX_WORDS = 256;
endpackage

// File: rtl/imem_loader_checksum.sv
// loader_checksum: registered modular sum of the loaded instruction words
module loader_checksum #(
   parameter int DSIZE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DSIZE-1:0] din,
   output logic [DSIZE-1:0] sum
);
   logic [DSIZE-1:0] sum_q, sum_d;
   // clear wins over accumulate; the add wraps modulo 2**DSIZE
   always_comb sum_d = clr ? '0 : en ? sum_q + din : sum_q;
   // accumulator register
   always_ff @(posedge clk) sum_q <= rst ? '0 : sum_d;
   assign sum = sum_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a host length/words/checksum stream
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ISIZE     = 16,
   parameter int DSIZE     = 16,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = LD_MAX_WORDS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [DSIZE-1:0] in_data,
   output logic             in_ready,
   output logic             mem_wen,
   output logic [ISIZE-1:0] mem_addr,
   output logic [DSIZE-1:0] mem_data,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [ISIZE-1:0] words_loaded
);
   ld_state_e        state_q, state_d;
   logic [ISIZE:0]   rem_q, rem_d;
   logic [ISIZE-1:0] words_loaded_q, words_loaded_d;
   logic [ISIZE-1:0] addr_q, addr_d;
   logic [DSIZE-1:0] data_q, data_d;
   logic             wen_q, wen_d, done_q, done_d, err_q, err_d;
   logic             ck_clr, ck_en;
   logic [DSIZE-1:0] sum;

   loader_checksum #(.DSIZE(DSIZE)) u_ck (
      .clk (clk),
      .rst (rst),
      .clr (ck_clr),
      .en  (ck_en),
      .din (in_data),
      .sum (sum)
   );

   assign busy     = state_q inside {LD_LEN, LD_LOAD, LD_CSUM};
   assign in_ready = busy;

   // next state, write register and sticky flags; words_loaded doubles as the address offset
   always_comb begin
      state_d        = state_q;
      rem_d          = rem_q;
      words_loaded_d = words_loaded_q;
      addr_d         = addr_q;
      data_d         = data_q;
      wen_d          = 1'b0;
      done_d         = done_q;
      err_d          = err_q;
      ck_clr         = 1'b0;
      ck_en          = 1'b0;
      case (state_q)
         LD_IDLE, LD_DONE, LD_ERR: if (start) begin
            state_d        = LD_LEN;
            done_d         = 1'b0;
            err_d          = 1'b0;
            words_loaded_d = '0;
            ck_clr         = 1'b1;
         end
         LD_LEN: if (in_valid) begin
            if (in_data == '0) state_d = LD_CSUM;
            else if (32'(in_data) > MAX_WORDS) begin
               state_d = LD_ERR;
               err_d   = 1'b1;
            end else begin
               state_d = LD_LOAD;
               rem_d   = (ISIZE+1)'(in_data);
            end
         end
         LD_LOAD: if (in_valid) begin
            ck_en          = 1'b1;
            wen_d          = 1'b1;
            addr_d         = ISIZE'(BASE_ADDR) + words_loaded_q;
            data_d         = in_data;
            words_loaded_d = words_loaded_q + ISIZE'(1);
            rem_d          = rem_q - (ISIZE+1)'(1);
            state_d        = rem_q == (ISIZE+1)'(1) ? LD_CSUM : LD_LOAD;
         end
         LD_CSUM: if (in_valid) begin
            state_d = in_data == sum ? LD_DONE : LD_ERR;
            done_d  = in_data == sum;
            err_d   = in_data != sum;
         end
         default: state_d = LD_IDLE;
      endcase
   end

   // state and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= LD_IDLE;
         rem_q          <= '0;
         words_loaded_q <= '0;
         addr_q         <= '0;
         data_q         <= '0;
         wen_q          <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         rem_q          <= rem_d;
         words_loaded_q <= words_loaded_d;
         addr_q         <= addr_d;
         data_q         <= data_d;
         wen_q          <= wen_d;
         done_q         <= done_d;
         err_q          <= err_d;
      end
   end

   assign mem_wen      = wen_q;
   assign mem_addr     = addr_q;
   assign mem_data     = data_q;
   assign cpu_hold     = busy | wen_q;
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = words_loaded_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the imem loader with a behavioural memory
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        rst, start, in_valid;
   logic [15:0] in_data;
   logic        in_ready, mem_wen, cpu_hold, busy, done, err;
   logic [15:0] mem_addr, mem_data, words_loaded;
   logic [15:0] mem [0:511];
   int          total = 0, bad = 0, wr_cnt = 0, base;

   imem_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .mem_wen      (mem_wen),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // imem model: commits at the edge that ends a mem_wen cycle
   always @(posedge clk) if (mem_wen) begin
      mem[mem_addr[8:0]] = mem_data;
      wr_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] w);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      tick(); tick();
      chk("rst_wen", mem_wen, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_flags", {busy, done, err}, 0);
      chk("rst_wl", words_loaded, 0);
      rst = 1'b0;
      tick();
      // 1: three-word load, data checksum 0x1123+0x2456+0x3789 = 0x6D02
      base = wr_cnt;
      go();
      chk("t1_busy", busy, 1);
      chk("t1_ready", in_ready, 1);
      send(16'd3);
      send(16'h1123);
      chk("t1_w0", {mem_wen, mem_addr, mem_data}, {1'b1, 16'd0, 16'h1123});
      chk("t1_wl1", words_loaded, 1);
      send(16'h2456);
      chk("t1_w1", {mem_wen, mem_addr, mem_data}, {1'b1, 16'd1, 16'h2456});
      send(16'h3789);
      chk("t1_w2", {mem_wen, mem_addr, mem_data}, {1'b1, 16'd2, 16'h3789});
      chk("t1_hold", cpu_hold, 1);
      send(16'h6D02);
      chk("t1_flags", {done, err}, 2'b10);
      chk("t1_hold_rel", cpu_hold, 0);
      chk("t1_wen_off", mem_wen, 0);
      chk("t1_wl", words_loaded, 3);
      chk("t1_nwr", wr_cnt - base, 3);
      chk("t1_mem", {mem[0], mem[1], mem[2]}, {16'h1123, 16'h2456, 16'h3789});
      // 2: empty loads with good and bad checksum
      base = wr_cnt;
      go();
      chk("t2_clr", done, 0);
      send(16'd0);
      send(16'h0000);
      chk("t2a_flags", {done, err}, 2'b10);
      chk("t2a_wl", words_loaded, 0);
      go();
      send(16'd0);
      send(16'h0001);
      chk("t2b_flags", {done, err}, 2'b01);
      chk("t2_nwr", wr_cnt - base, 0);
      // 3: oversize length, then a good one-word load clears the error
      base = wr_cnt;
      go();
      send(16'd257);
      chk("t3_err", {done, err}, 2'b01);
      chk("t3_ready", in_ready, 0);
      chk("t3_busy", busy, 0);
      send(16'h5555);
      chk("t3_nwr", wr_cnt - base, 0);
      go();
      chk("t3_errclr", err, 0);
      send(16'd1);
      send(16'hABCD);
      chk("t3_w0", {mem_wen, mem_addr, mem_data}, {1'b1, 16'd0, 16'hABCD});
      send(16'hABCD);
      chk("t3_flags", {done, err}, 2'b10);
      chk("t3_mem", mem[0], 16'hABCD);
      // 4: stalled stream, hold stays high until DONE
      base = wr_cnt;
      go();
      send(16'd2);
      send(16'h1111);
      chk("t4_w0", {mem_wen, mem_addr}, {1'b1, 16'd0});
      tick();
      chk("t4_stall1", {mem_wen, cpu_hold, mem_addr}, {1'b0, 1'b1, 16'd0});
      tick();
      chk("t4_stall2", {mem_wen, cpu_hold, mem_data}, {1'b0, 1'b1, 16'h1111});
      send(16'h2222);
      chk("t4_w1", {mem_wen, mem_addr, cpu_hold}, {1'b1, 16'd1, 1'b1});
      send(16'h3333);
      chk("t4_done", {done, err, cpu_hold}, 3'b100);
      chk("t4_nwr", wr_cnt - base, 2);
      chk("t4_mem", {mem[0], mem[1]}, {16'h1111, 16'h2222});
      // 5: reset right after the second data word is accepted
      base = wr_cnt;
      go();
      send(16'd4);
      send(16'h0A0A);
      send(16'h0B0B);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 16'h0C0C;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      chk("t5_out", {mem_wen, in_ready, cpu_hold, busy, done, err}, 0);
      chk("t5_wl", words_loaded, 0);
      chk("t5_addr", {mem_addr, mem_data}, 0);
      tick();
      chk("t5_nwr", wr_cnt - base, 2);
      chk("t5_mem", mem[1], 16'h0B0B);
      // 6: start during LOAD is ignored
      base = wr_cnt;
      go();
      send(16'd2);
      send(16'h0101);
      start = 1'b1;
      send(16'h0202);
      start = 1'b0;
      chk("t6_wl", words_loaded, 2);
      chk("t6_w1", {mem_wen, mem_addr}, {1'b1, 16'd1});
      send(16'h0303);
      chk("t6_flags", {done, err}, 2'b10);
      chk("t6_nwr", wr_cnt - base, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
